tx_core_cfg_sequencer: RTL and testbench



---
 rtl/tx_core_cfg_pkg.sv | 34 +++
 rtl/tx_core_cfg_sequencer_gain_ramp.sv | 58 +++++
 rtl/tx_core_cfg_sequencer.sv | 170 +++++++++++++++++
 tb/tb_tx_core_cfg_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_core_cfg_pkg.sv
// ============================================================================
// Module      : tx_core_cfg_pkg
// Description : Shared widths, FSM state codes and config addresses for the
//               TX core configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_core_cfg_pkg;

    localparam int GAIN_W  = 8;
    localparam int PHASE_W = 16;
    localparam int SCALE_W = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 16;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_MUTE_DOWN = 3'd1;
    localparam state_t ST_APPLY     = 3'd2;
    localparam state_t ST_SETTLE    = 3'd3;
    localparam state_t ST_RAMP_UP   = 3'd4;

    localparam logic [ADDR_W-1:0] CFG_GAIN    = 3'd0;
    localparam logic [ADDR_W-1:0] CFG_PHASE   = 3'd1;
    localparam logic [ADDR_W-1:0] CFG_MODE    = 3'd2;
    localparam logic [ADDR_W-1:0] CFG_COMMIT  = 3'd3;
    localparam logic [ADDR_W-1:0] CFG_OVL_CLR = 3'd4;

endpackage

`default_nettype wire

// File: rtl/tx_core_cfg_sequencer_gain_ramp.sv
// ============================================================================
// Module      : gain_ramp
// Description : Steps the mixer gain toward a target by at most RAMP_STEP
//               every RAMP_DIV enabled cycles, without overshoot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gain_ramp
    import tx_core_cfg_pkg::*;
#(
    parameter int RAMP_STEP = 4,
    parameter int RAMP_DIV  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_enable,
    input  logic [GAIN_W-1:0] i_target,
    output logic [GAIN_W-1:0] o_gain,
    output logic              o_at_target
);

    localparam int              c_div_w = $clog2(RAMP_DIV + 1);
    localparam logic [GAIN_W-1:0] c_step = GAIN_W'(RAMP_STEP);

    logic [c_div_w-1:0] r_div;
    logic [GAIN_W-1:0]  r_gain;
    logic               w_up;
    logic               w_tick;
    logic [GAIN_W-1:0]  w_diff;
    logic [GAIN_W-1:0]  w_step;

    assign w_up   = i_target > r_gain;
    assign w_diff = w_up ? (i_target - r_gain) : (r_gain - i_target);
    // Clamp the last step to the remaining distance so the gain never wraps.
    assign w_step = (w_diff < c_step) ? w_diff : c_step;
    assign w_tick = (r_div == c_div_w'(RAMP_DIV - 1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_div  <= '0;
            r_gain <= '0;
        end else if (!i_enable) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_gain <= w_up ? (r_gain + w_step) : (r_gain - w_step);
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_gain      = r_gain;
    assign o_at_target = (r_gain == i_target);

endmodule

`default_nettype wire

// File: rtl/tx_core_cfg_sequencer.sv
// ============================================================================
// Module      : tx_core_cfg_sequencer
// Description : Stages TX DSP run-time settings and applies them on commit with
//               a glitch-free mute/apply/settle/ramp sequence; overload monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_core_cfg_sequencer
    import tx_core_cfg_pkg::*;
#(
    parameter int               RAMP_STEP     = 4,
    parameter int               RAMP_DIV      = 16,
    parameter int               SETTLE_CYCLES = 64,
    parameter logic [DATA_W-1:0] OVL_THRESHOLD = 16'h7000,
    parameter int               OVL_COUNT     = 256
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]  cfg_data,
    input  logic [DATA_W-1:0]  interval_max,
    output logic [GAIN_W-1:0]  mixer_gain,
    output logic [PHASE_W-1:0] lo_dds_phase_inc,
    output logic               enable_pre_distortion,
    output logic [SCALE_W-1:0] scale_select,
    output logic               busy,
    output logic               overload
);

    localparam int c_settle_w = $clog2(SETTLE_CYCLES + 1);
    localparam int c_ovl_w    = $clog2(OVL_COUNT + 1);

    state_t              r_state;
    logic [GAIN_W-1:0]   r_stg_gain;
    logic [PHASE_W-1:0]  r_stg_phase;
    logic [SCALE_W-1:0]  r_stg_scale;
    logic                r_stg_pd;
    logic [PHASE_W-1:0]  r_phase;
    logic [SCALE_W-1:0]  r_scale;
    logic                r_pd;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [c_ovl_w-1:0]  r_ovl_cnt;
    logic                r_overload;

    logic                w_accept;
    logic                w_commit;
    logic                w_struct_diff;
    logic                w_gain_diff;
    logic                w_ramp_en;
    logic [GAIN_W-1:0]   w_target;
    logic [GAIN_W-1:0]   w_gain;
    logic                w_at_target;
    logic [c_ovl_w-1:0]  w_ovl_cnt_nxt;
    logic                w_ovl_set;
    logic                w_ovl_clr;

    assign cfg_ready     = resetn && (r_state == ST_IDLE);
    assign w_accept      = cfg_valid && cfg_ready;
    assign w_commit      = w_accept && (cfg_addr == CFG_COMMIT);
    assign w_struct_diff = (r_stg_phase != r_phase) || (r_stg_scale != r_scale) ||
                           (r_stg_pd != r_pd);
    assign w_gain_diff   = (r_stg_gain != w_gain);
    assign w_ramp_en     = (r_state == ST_MUTE_DOWN) || (r_state == ST_RAMP_UP);
    assign w_target      = (r_state == ST_MUTE_DOWN) ? '0 : r_stg_gain;

    gain_ramp #(
        .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV)
    ) u_gain_ramp (
        .clock       (clock),
        .resetn      (resetn),
        .i_enable    (w_ramp_en),
        .i_target    (w_target),
        .o_gain      (w_gain),
        .o_at_target (w_at_target)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_stg_gain   <= '0;
            r_stg_phase  <= '0;
            r_stg_scale  <= '0;
            r_stg_pd     <= 1'b0;
            r_phase      <= '0;
            r_scale      <= '0;
            r_pd         <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            if (w_accept) begin
                case (cfg_addr)
                    CFG_GAIN:  r_stg_gain  <= cfg_data[GAIN_W-1:0];
                    CFG_PHASE: r_stg_phase <= cfg_data;
                    CFG_MODE: begin
                        r_stg_pd    <= cfg_data[4];
                        r_stg_scale <= cfg_data[3:0];
                    end
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_commit && w_struct_diff) begin
                        r_state <= ST_MUTE_DOWN;
                    end else if (w_commit && w_gain_diff) begin
                        r_state <= ST_RAMP_UP;
                    end
                end
                ST_MUTE_DOWN: if (w_at_target) r_state <= ST_APPLY;
                ST_APPLY: begin
                    r_phase      <= r_stg_phase;
                    r_scale      <= r_stg_scale;
                    r_pd         <= r_stg_pd;
                    r_settle_cnt <= '0;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == c_settle_w'(SETTLE_CYCLES - 1)) begin
                        r_state <= ST_RAMP_UP;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_RAMP_UP: if (w_at_target) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ovl_cnt_nxt = r_ovl_cnt;
        if (interval_max <= OVL_THRESHOLD) begin
            w_ovl_cnt_nxt = '0;
        end else if (r_ovl_cnt != c_ovl_w'(OVL_COUNT)) begin
            w_ovl_cnt_nxt = r_ovl_cnt + 1'b1;
        end
    end

    // A saturated counter keeps re-asserting set, so it beats a coincident clear.
    assign w_ovl_set = (w_ovl_cnt_nxt == c_ovl_w'(OVL_COUNT));
    assign w_ovl_clr = w_accept && (cfg_addr == CFG_OVL_CLR);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ovl_cnt  <= '0;
            r_overload <= 1'b0;
        end else begin
            r_ovl_cnt <= w_ovl_cnt_nxt;
            if (w_ovl_set) begin
                r_overload <= 1'b1;
            end else if (w_ovl_clr) begin
                r_overload <= 1'b0;
            end
        end
    end

    assign mixer_gain            = w_gain;
    assign lo_dds_phase_inc      = r_phase;
    assign scale_select          = r_scale;
    assign enable_pre_distortion = r_pd;
    assign busy                  = (r_state != ST_IDLE);
    assign overload              = r_overload;

endmodule

`default_nettype wire

// File: tb/tb_tx_core_cfg_sequencer.sv
// ============================================================================
// Module      : tb_tx_core_cfg_sequencer
// Description : Randomized self-checking bench with a trajectory-level model
//               of commit sequences and a run-length model of the overload flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_core_cfg_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic [15:0] interval_max = '0;
    logic [7:0]  mixer_gain;
    logic [15:0] lo_dds_phase_inc;
    logic        enable_pre_distortion;
    logic [3:0]  scale_select;
    logic        busy;
    logic        overload;

    tx_core_cfg_sequencer dut (
        .clock                 (clock),
        .resetn                (resetn),
        .cfg_valid             (cfg_valid),
        .cfg_ready             (cfg_ready),
        .cfg_addr              (cfg_addr),
        .cfg_data              (cfg_data),
        .interval_max          (interval_max),
        .mixer_gain            (mixer_gain),
        .lo_dds_phase_inc      (lo_dds_phase_inc),
        .enable_pre_distortion (enable_pre_distortion),
        .scale_select          (scale_select),
        .busy                  (busy),
        .overload              (overload)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit busy;
        int gain;
        int phase;
        int mode;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   m_gain, m_phase, m_mode;
    int   s_gain, s_phase, s_mode;
    int   ovl_run;
    bit   ovl_m;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_gain = 0; m_phase = 0; m_mode = 0;
        s_gain = 0; s_phase = 0; s_mode = 0;
        ovl_run = 0; ovl_m = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_valid = 1'b1;
        cfg_addr  = 3'(a);
        cfg_data  = 16'(d);
        tick();
        cfg_valid = 1'b0;
        case (a)
            0: s_gain  = d & 'hff;
            1: s_phase = d & 'hffff;
            2: s_mode  = d & 'h1f;
            default: ;
        endcase
    endtask

    task automatic push_exp(input bit b, input int g, input int p, input int m);
        exp_t e;
        e.busy = b; e.gain = g; e.phase = p; e.mode = m;
        q.push_back(e);
    endtask

    // Samples 0..L of a ramp from a to b, L = ceil(|b-a|/4)*16.
    task automatic push_seg(input int a, input int b, input int p, input int m);
        int d, len, mv;
        d   = (b > a) ? b - a : a - b;
        len = ((d + 3) / 4) * 16;
        for (int j = 0; j <= len; j++) begin
            mv = (j / 16) * 4;
            if (mv > d) mv = d;
            push_exp(1'b1, (b >= a) ? a + mv : a - mv, p, m);
        end
    endtask

    task automatic do_commit(input string tag);
        q.delete();
        if (s_phase != m_phase || s_mode != m_mode) begin
            push_seg(m_gain, 0, m_phase, m_mode);
            push_exp(1'b1, 0, m_phase, m_mode);
            for (int k = 0; k < 64; k++) push_exp(1'b1, 0, s_phase, s_mode);
            push_seg(0, s_gain, s_phase, s_mode);
        end else if (s_gain != m_gain) begin
            push_seg(m_gain, s_gain, m_phase, m_mode);
        end
        m_gain = s_gain; m_phase = s_phase; m_mode = s_mode;
        for (int k = 0; k < 3; k++) push_exp(1'b0, m_gain, m_phase, m_mode);
        cfg_write(3, 0);
        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) tick();
            check_val({tag, "_busy"}, 32'(busy), 32'(q[i].busy));
            check_val({tag, "_gain"}, 32'(mixer_gain), 32'(q[i].gain));
            check_val({tag, "_phase"}, 32'(lo_dds_phase_inc), 32'(q[i].phase));
            check_val({tag, "_mode"}, 32'({enable_pre_distortion, scale_select}), 32'(q[i].mode));
            check_val({tag, "_ready"}, 32'(cfg_ready), 32'(!q[i].busy));
        end
    endtask

    task automatic ovl_step(input string tag, input int im, input bit clr);
        interval_max = 16'(im);
        if (clr) begin
            cfg_valid = 1'b1;
            cfg_addr  = 3'd4;
        end
        tick();
        cfg_valid = 1'b0;
        if (im > 'h7000) ovl_run = (ovl_run < 256) ? ovl_run + 1 : 256;
        else             ovl_run = 0;
        if (ovl_run >= 256) ovl_m = 1'b1;
        else if (clr)       ovl_m = 1'b0;
        check_val(tag, 32'(overload), 32'(ovl_m));
    endtask

    initial begin
        int hi, len, val, lmute;
        model_reset();
        repeat (3) tick();
        check_val("rst_gain", 32'(mixer_gain), 32'd0);
        check_val("rst_phase", 32'(lo_dds_phase_inc), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovl", 32'(overload), 32'd0);
        check_val("rst_ready", 32'(cfg_ready), 32'd0);
        resetn = 1'b1;
        tick();
        check_val("ready_out_of_rst", 32'(cfg_ready), 32'd1);

        cfg_write(0, 'h40);
        do_commit("gain40");
        cfg_write(1, 'h1234);
        do_commit("ph1234");
        do_commit("noop");
        cfg_write(6, 'hbeef);
        do_commit("unused_addr");

        for (int n = 0; n < 5; n++) begin
            if ($urandom_range(0, 3) != 0) cfg_write(0, $urandom_range(0, 255));
            if ($urandom_range(0, 1) != 0) cfg_write(1, $urandom_range(0, 'hffff));
            if ($urandom_range(0, 1) != 0) cfg_write(2, $urandom_range(0, 'hffff));
            do_commit("rand");
        end

        for (int k = 0; k < 255; k++) ovl_step("ovl_255", 'h7001, 1'b0);
        for (int k = 0; k < 5; k++)   ovl_step("ovl_drop", 'h6000, 1'b0);
        for (int k = 0; k < 256; k++) ovl_step("ovl_256", 'h7001, 1'b0);
        ovl_step("ovl_set_wins", 'h7001, 1'b1);
        for (int k = 0; k < 10; k++)  ovl_step("ovl_sticky", 'h6000, 1'b0);
        ovl_step("ovl_clear", 'h6000, 1'b1);
        for (int r = 0; r < 10; r++) begin
            hi  = $urandom_range(0, 1);
            len = hi ? $urandom_range(240, 300) : $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                val = hi ? $urandom_range('h7001, 'hffff) : $urandom_range(0, 'h7000);
                ovl_step("ovl_rand", val, $urandom_range(0, 15) == 0);
            end
        end
        interval_max = '0;
        for (int k = 0; k < 300; k++) ovl_step("ovl_quiet", 0, k == 0);

        // Reset pulse in the middle of SETTLE.
        cfg_write(0, 'h20);
        cfg_write(1, m_phase ^ 'h5555);
        lmute = ((m_gain + 3) / 4) * 16;
        cfg_write(3, 0);
        repeat (lmute + 12) tick();
        check_val("settle_busy", 32'(busy), 32'd1);
        check_val("settle_gain", 32'(mixer_gain), 32'd0);
        resetn = 1'b0;
        tick();
        model_reset();
        check_val("mid_rst_gain", 32'(mixer_gain), 32'd0);
        check_val("mid_rst_phase", 32'(lo_dds_phase_inc), 32'd0);
        check_val("mid_rst_mode", 32'({enable_pre_distortion, scale_select}), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_ready", 32'(cfg_ready), 32'd0);
        resetn = 1'b1;
        tick();
        check_val("post_rst_ready", 32'(cfg_ready), 32'd1);
        do_commit("post_rst_noop");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
